// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the access-size encodings, the LSU state enum, the data width and
// the per-size byte-lane masks, plus small helpers used when decoding a
// request.
package dmem_pkg;

   localparam int DATA_W = 32;

   // req_size encodings
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   // LSU sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC0 = 2'b01,
      ST_ACC1 = 2'b10,
      ST_RSP  = 2'b11
   } state_e;

   // Unshifted byte-lane masks over an 8-lane (two word) window
   localparam logic [7:0] LANE_MASK_BYTE = 8'h01;
   localparam logic [7:0] LANE_MASK_HALF = 8'h03;
   localparam logic [7:0] LANE_MASK_WORD = 8'h0F;

   // Number of bytes touched by an access; reserved size is treated as a
   // word so the split test stays well defined (it is trapped anyway).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: lane_mask = LANE_MASK_BYTE;
         SZ_HALF: lane_mask = LANE_MASK_HALF;
         default: lane_mask = LANE_MASK_WORD;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank_be.sv
// Word-organised data RAM with per-byte write enables.
// One write port and one synchronous read port; read data is registered and
// only changes on a cycle where re is asserted. Contents are never reset.
//   clk    : clock
//   we     : byte write enables, bit i writes wdata[8i+7:8i]
//   waddr  : write word address
//   wdata  : write data
//   re     : read enable
//   raddr  : read word address
//   rdata  : registered read data
module dmem_bank_be
  import dmem_pkg::*;
#(
  parameter int    MEM_DEPTH = 1024,
  parameter string MEMDATA   = "",
  localparam int   AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enabled data RAM.
// Accepts one request at a time, handles byte/half/word accesses at any byte
// offset (splitting across two words or trapping, by MISALIGN_MODE), and
// returns one response per request with a valid/ready handshake.
//   clk, rst      : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_we        : 1 = store, 0 = load
//   req_addr      : byte address
//   req_size      : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  : zero-extend byte/half loads
//   req_wdata     : right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata     : extended load data, 0 for stores and errors
//   rsp_err       : trapped misaligned access or reserved size
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int    MEM_DEPTH     = 1024,
   parameter string MEMDATA       = "",
   parameter int    MISALIGN_MODE = 1,
   localparam int   ADDR_W        = $clog2(MEM_DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int WORD_W = ADDR_W - 2;

   state_e state, state_nxt;

   // Registered request
   logic              we_q;
   logic              unsigned_q;
   logic [1:0]        size_q;
   logic [1:0]        off_q;
   logic [WORD_W-1:0] widx_q;
   logic [DATA_W-1:0] wdata_q;
   logic              split_q;
   logic              err_q;
   logic [DATA_W-1:0] word0_q;

   logic              accept;
   logic              split_in;
   logic              err_in;

   logic              access;
   logic [7:0]        lanes;
   logic [63:0]       wdata_sh;
   logic [3:0]        mem_we;
   logic              mem_re;
   logic [WORD_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] ld_raw;
   logic [DATA_W-1:0] ld_ext;

   // ---------------------------------------------------------------- decode
   assign accept = req_valid && req_ready;

   always_comb begin
      split_in = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
      err_in   = (req_size == SZ_RSVD) || ((MISALIGN_MODE == 0) && split_in);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q       <= req_we;
         unsigned_q <= req_unsigned;
         size_q     <= req_size;
         off_q      <= req_addr[1:0];
         widx_q     <= req_addr[ADDR_W-1:2];
         wdata_q    <= req_wdata;
         split_q    <= split_in;
         err_q      <= err_in;
      end
      // The first word of a split load arrives while the second is being read
      if (state == ST_ACC1) begin
         word0_q <= mem_rdata;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = ST_ACC0;
         ST_ACC0: state_nxt = (split_q && !err_q) ? ST_ACC1 : ST_RSP;
         ST_ACC1: state_nxt = ST_RSP;
         ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      rsp_valid = (state == ST_RSP);
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_ext : '0;
   end

   // ---------------------------------------------------------------- memory side
   always_comb begin
      access    = !err_q && ((state == ST_ACC0) || (state == ST_ACC1));
      lanes     = lane_mask(size_q) << off_q;
      wdata_sh  = {32'h0, wdata_q} << {off_q, 3'b000};
      mem_addr  = (state == ST_ACC1) ? widx_q + 1'b1 : widx_q;
      mem_wdata = (state == ST_ACC1) ? wdata_sh[63:32] : wdata_sh[31:0];
      mem_re    = access && !we_q;
      mem_we    = '0;
      // Writes are blocked while reset is asserted so an interrupted split
      // store never touches its second word.
      if (access && we_q && rst) begin
         mem_we = (state == ST_ACC1) ? lanes[7:4] : lanes[3:0];
      end
   end

   dmem_bank_be #(
      .MEM_DEPTH (MEM_DEPTH),
      .MEMDATA   (MEMDATA)
   ) u_bank (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_addr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (mem_addr),
      .rdata (mem_rdata)
   );

   // ---------------------------------------------------------------- load path
   // In RSP the RAM output holds the last word read: word0 when unsplit,
   // word1 when split (word0 then comes from word0_q).
   always_comb begin
      ld_raw = 32'({(split_q ? mem_rdata : 32'h0),
                    (split_q ? word0_q   : mem_rdata)} >> {off_q, 3'b000});
      case (size_q)
         SZ_BYTE: ld_ext = {{24{!unsigned_q && ld_raw[7]}},  ld_raw[7:0]};
         SZ_HALF: ld_ext = {{16{!unsigned_q && ld_raw[15]}}, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a split-mode and a trap-mode instance
// (both 16 words deep) share stimulus; a byte-level reference memory per
// instance produces expected responses, which are queued at issue time and
// compared when the response handshake occurs.
module tb_dmem_lsu;

   localparam int AW = 6;
   localparam int NB = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic        sel = 1'b0;

   logic        vs, vt;
   logic        rdy_s, rdy_t, rv_s, rv_t, re_s, re_t;
   logic [31:0] rd_s, rd_t;
   logic        rdy, rv, re;
   logic [31:0] rd;

   always #5 clk = ~clk;

   assign vs  = req_valid & ~sel;
   assign vt  = req_valid & sel;
   assign rdy = sel ? rdy_t : rdy_s;
   assign rv  = sel ? rv_t  : rv_s;
   assign re  = sel ? re_t  : re_s;
   assign rd  = sel ? rd_t  : rd_s;

   dmem_lsu #(.MEM_DEPTH(16), .MISALIGN_MODE(1)) dut_s (
      .clk(clk), .rst(rst), .req_valid(vs), .req_ready(rdy_s), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rv_s), .rsp_ready(rsp_ready),
      .rsp_rdata(rd_s), .rsp_err(re_s));

   dmem_lsu #(.MEM_DEPTH(16), .MISALIGN_MODE(0)) dut_t (
      .clk(clk), .rst(rst), .req_valid(vt), .req_ready(rdy_t), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rv_t), .rsp_ready(rsp_ready),
      .rsp_rdata(rd_t), .rsp_err(re_t));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mdl [2][NB];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: byte-addressed memory, wrap modulo the memory size
   task automatic model_push(input logic s, input logic we, input logic [AW-1:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata);
      exp_t        e;
      int          nb;
      bit          split;
      logic [31:0] v, m;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      split = (int'(addr) % 4) + nb > 4;
      e.rdata = '0;
      e.err   = 1'b0;
      e.lat   = 2;
      if (size == 2'd3 || (s && split)) begin
         e.err = 1'b1;
      end else begin
         if (split) e.lat = 3;
         if (we) begin
            for (int i = 0; i < nb; i++) mdl[int'(s)][(int'(addr) + i) % NB] = wdata[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[int'(s)][(int'(addr) + i) % NB];
            if (nb < 4 && !uns && v[8*nb-1]) begin
               m = (32'd1 << (8*nb)) - 32'd1;
               v = v | ~m;
            end
            e.rdata = v;
         end
      end
      sb.push_back(e);
   endtask

   task automatic do_req(input logic s, input logic we, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input int hold, output logic [31:0] got);
      exp_t e;
      int   lat;
      sel          = s;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      rsp_ready    = (hold == 0);
      model_push(s, we, addr, size, uns, wdata);
      chk("req_ready_idle", rdy, 1);
      tick;
      req_valid = 1'b0;
      lat = 1;
      while (!rv && lat < 20) begin
         tick;
         lat++;
      end
      e = sb.pop_front();
      chk("rsp_valid_seen", rv, 1);
      chk("latency", lat, e.lat);
      chk("rsp_err", re, e.err);
      chk("rsp_rdata", rd, e.rdata);
      got = rd;
      for (int h = 0; h < hold; h++) begin
         tick;
         chk("hold_valid", rv, 1);
         chk("hold_rdata", rd, e.rdata);
         chk("hold_err", re, e.err);
         chk("hold_req_ready", rdy, 0);
      end
      rsp_ready = 1'b1;
      tick;
      chk("rsp_valid_drop", rv, 0);
      chk("req_ready_back", rdy, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;

      // Reset state on both instances
      tick;
      tick;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_req_ready", rdy, 1);
         chk("rst_rsp_valid", rv, 0);
         chk("rst_rsp_err", re, 0);
         chk("rst_rsp_rdata", rd, 0);
      end
      rst = 1'b1;
      tick;

      // Fill every word so later loads have defined contents
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 16; w++)
            do_req(1'(s), 1'b1, AW'(4*w), 2'd2, 1'b0, $urandom, 0, got);

      // Word store then signed byte load of its top byte
      do_req(0, 1, 6'h10, 2'd2, 0, 32'hDEADBEEF, 0, got);
      do_req(0, 0, 6'h13, 2'd0, 0, 32'h0, 0, got);
      chk("byte_signed_de", got, 32'hFFFFFFDE);
      do_req(0, 0, 6'h13, 2'd0, 1, 32'h0, 0, got);
      chk("byte_unsigned_de", got, 32'h000000DE);
      do_req(0, 0, 6'h12, 2'd1, 0, 32'h0, 0, got);
      chk("half_signed_dead", got, 32'hFFFFDEAD);

      // Split half store across words 1/2
      do_req(0, 1, 6'h07, 2'd1, 0, 32'h0000A55A, 0, got);
      do_req(0, 0, 6'h04, 2'd2, 0, 32'h0, 0, got);
      chk("split_w1_top", got & 32'hFF000000, 32'h5A000000);
      do_req(0, 0, 6'h08, 2'd2, 0, 32'h0, 0, got);
      chk("split_w2_low", got & 32'h000000FF, 32'h000000A5);
      do_req(0, 0, 6'h07, 2'd1, 0, 32'h0, 0, got);
      chk("split_half_s", got, 32'hFFFFA55A);
      do_req(0, 0, 6'h07, 2'd1, 1, 32'h0, 0, got);
      chk("split_half_u", got, 32'h0000A55A);

      // Wrap from the last word to word 0
      do_req(0, 1, 6'h3E, 2'd2, 0, 32'h11223344, 0, got);
      do_req(0, 0, 6'h3C, 2'd2, 0, 32'h0, 0, got);
      chk("wrap_w15_hi", got & 32'hFFFF0000, 32'h33440000);
      do_req(0, 0, 6'h00, 2'd2, 0, 32'h0, 0, got);
      chk("wrap_w0_lo", got & 32'h0000FFFF, 32'h00001122);
      do_req(0, 0, 6'h3E, 2'd2, 0, 32'h0, 0, got);
      chk("wrap_word", got, 32'h11223344);

      // Reserved size on the split instance
      do_req(0, 0, 6'h00, 2'd3, 0, 32'h0, 0, got);

      // Trap mode: misaligned accesses do nothing
      do_req(1, 1, 6'h00, 2'd2, 0, 32'h12345678, 0, got);
      do_req(1, 0, 6'h02, 2'd2, 0, 32'h0, 0, got);
      do_req(1, 1, 6'h02, 2'd2, 0, 32'hFFFFFFFF, 0, got);
      do_req(1, 1, 6'h03, 2'd1, 0, 32'h0000FFFF, 0, got);
      do_req(1, 0, 6'h00, 2'd2, 0, 32'h0, 0, got);
      chk("trap_mem_kept", got, 32'h12345678);
      do_req(1, 0, 6'h02, 2'd1, 0, 32'h0, 0, got);
      chk("trap_half_ok", got, 32'h00001234);

      // Back-pressure on the response
      do_req(0, 0, 6'h10, 2'd2, 0, 32'h0, 5, got);
      do_req(0, 1, 6'h05, 2'd2, 0, 32'h01020304, 3, got);

      // Mixed random traffic on both instances
      for (int k = 0; k < 60; k++)
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NB-1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                (k % 9 == 0) ? 2 : 0, got);

      // Reset during the second half of a split store
      sel          = 1'b0;
      req_we       = 1'b1;
      req_addr     = 6'h21;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_wdata    = 32'hCAFEBABE;
      req_valid    = 1'b1;
      tick;
      req_valid = 1'b0;
      tick;
      chk("acc1_req_ready", rdy, 0);
      chk("acc1_rsp_valid", rv, 0);
      rst = 1'b0;
      tick;
      chk("mid_rst_req_ready", rdy, 1);
      chk("mid_rst_rsp_valid", rv, 0);
      chk("mid_rst_rsp_err", re, 0);
      chk("mid_rst_rsp_rdata", rd, 0);
      rst = 1'b1;
      tick;
      chk("post_rst_rsp_valid", rv, 0);
      mdl[0][6'h21] = 8'hBE;
      mdl[0][6'h22] = 8'hBA;
      mdl[0][6'h23] = 8'hFE;
      do_req(0, 0, 6'h20, 2'd2, 0, 32'h0, 0, got);
      chk("rst_first_word", got & 32'hFFFFFF00, 32'hFEBABE00);
      do_req(0, 0, 6'h24, 2'd2, 0, 32'h0, 0, got);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
